memory_access: RTL and testbench

Memory stage of the five-stage pipeline. Consumes the `M_type` bundle registered after `execute`, issues at most one data-bus transaction per load or store, and produces the `W_type` bundle for write-back. It stalls the pipeline with `pcm_stall` while a transaction is outstanding. It also performs byte-lane steering, sign extension, partial-word merges and address-alignment exception detection.

---
 rtl/memory_access_pkg.sv | 74 +++++++
 rtl/memory_access_mem_align.sv | 88 ++++++++
 rtl/memory_access.sv | 164 ++++++++++++++++
 tb/tb_memory_access.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: opcodes, bus sizes, exception flags,
// the M/W pipeline bundles and the memory-stage FSM state encoding.
package memory_access_pkg;

  typedef logic [4:0] op_t;

  localparam op_t OP_NOP = 5'd0;
  localparam op_t OP_LB  = 5'd1;
  localparam op_t OP_LBU = 5'd2;
  localparam op_t OP_LH  = 5'd3;
  localparam op_t OP_LHU = 5'd4;
  localparam op_t OP_LW  = 5'd5;
  localparam op_t OP_LWL = 5'd6;
  localparam op_t OP_LWR = 5'd7;
  localparam op_t OP_SB  = 5'd8;
  localparam op_t OP_SH  = 5'd9;
  localparam op_t OP_SW  = 5'd10;
  localparam op_t OP_SWL = 5'd11;
  localparam op_t OP_SWR = 5'd12;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef struct packed {
    logic ADEL;
    logic ADES;
    logic RI;
    logic OV;
    logic SYSCALL;
    logic BREAK;
  } exp_t;

  typedef struct packed {
    op_t         OP;
    logic [31:0] valA;
    logic [31:0] valB;
    logic        rm;
    logic        wm;
    logic        regw;
    logic [31:0] pc;
    exp_t        exp;
    logic        hi_w;
    logic        lo_w;
    logic [4:0]  t;
  } M_type;

  typedef struct packed {
    logic [31:0] valA;
    logic [31:0] valB;
    logic        regw;
    logic [31:0] pc;
    exp_t        exp;
    logic        hi_w;
    logic        lo_w;
    logic [4:0]  t;
    logic [31:0] badvaddr;
  } W_type;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } ma_state_t;

  // LWL/LWR/SWL/SWR: word-aligned partial-word merges
  function automatic logic is_merge_op(op_t op);
    return (op == OP_LWL) || (op == OP_LWR) || (op == OP_SWL) || (op == OP_SWR);
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational byte-lane steering: load extraction with sign/zero
// extension and partial-word merge, store lane/strobe generation, and the
// bus address/size for each op.
module mem_align
  import memory_access_pkg::*;
(
  input  op_t         op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] req_addr_o,
  output msize_t      req_size_o,
  output logic [3:0]  strobe_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [1:0]  k;
  logic [4:0]  sh_lo;   // 8*k
  logic [4:0]  sh_hi;   // 8*(3-k)
  logic [31:0] ones;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign k     = addr_i[1:0];
  assign sh_lo = {k, 3'b000};
  assign sh_hi = {~k, 3'b000};
  assign ones  = '1;

  // Select the addressed byte/half of the returned word
  always_comb begin
    rbyte = 8'(rdata_i >> sh_lo);
    rhalf = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Load result extraction
  always_comb begin
    load_o = rdata_i;
    case (op_i)
      OP_LB:   load_o = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_o = {24'h0, rbyte};
      OP_LH:   load_o = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_o = {16'h0, rhalf};
      OP_LWL:  load_o = (rdata_i << sh_hi) | (rt_i & ~(ones << sh_hi));
      OP_LWR:  load_o = (rdata_i >> sh_lo) | (rt_i & ~(ones >> sh_lo));
      default: load_o = rdata_i;
    endcase
  end

  // Request address, size, strobes and lane-aligned store data
  always_comb begin
    req_addr_o = addr_i;
    req_size_o = MSIZE4;
    strobe_o   = '0;
    wdata_o    = '0;
    case (op_i)
      OP_LB, OP_LBU: req_size_o = MSIZE1;
      OP_LH, OP_LHU: req_size_o = MSIZE2;
      OP_LWL, OP_LWR: req_addr_o = {addr_i[31:2], 2'b00};
      OP_SB: begin
        req_size_o = MSIZE1;
        strobe_o   = 4'b0001 << k;
        wdata_o    = {4{rt_i[7:0]}};
      end
      OP_SH: begin
        req_size_o = MSIZE2;
        strobe_o   = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o    = {2{rt_i[15:0]}};
      end
      OP_SW: begin
        strobe_o = '1;
        wdata_o  = rt_i;
      end
      OP_SWL: begin
        req_addr_o = {addr_i[31:2], 2'b00};
        strobe_o   = 4'b1111 >> (~k);
        wdata_o    = rt_i >> sh_hi;
      end
      OP_SWR: begin
        req_addr_o = {addr_i[31:2], 2'b00};
        strobe_o   = 4'b1111 << k;
        wdata_o    = rt_i << sh_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues one data-bus transaction per load/store, stalls the
// pipeline while it is outstanding, detects misaligned accesses and builds
// the write-back bundle.
// Optional feature: define MEM_UNALIGNED_EN to execute LWL/LWR/SWL/SWR;
// otherwise those ops raise a reserved-instruction exception.
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  M_type       M,
  input  logic        m_valid,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output W_type       W_pre,
  output logic        w_valid,
  output logic        pcm_stall
);

  ma_state_t   state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] res_q, res_d;

  msize_t      req_size;
  logic [31:0] load_data;
  logic        is_mem, ade_l, ade_s, ri, fault, issue;

  mem_align u_align (
    .op_i       (M.OP),
    .addr_i     (M.valA),
    .rt_i       (M.valB),
    .rdata_i    (dresp_data),
    .req_addr_o (dreq_addr),
    .req_size_o (req_size),
    .strobe_o   (dreq_strobe),
    .wdata_o    (dreq_data),
    .load_o     (load_data)
  );

  assign dreq_size = req_size;

  // Alignment and reserved-op exception detection
  always_comb begin
    is_mem = M.rm | M.wm;
    ade_l  = ((M.OP == OP_LW) && (M.valA[1:0] != 2'b00)) ||
             (((M.OP == OP_LH) || (M.OP == OP_LHU)) && M.valA[0]);
    ade_s  = ((M.OP == OP_SW) && (M.valA[1:0] != 2'b00)) ||
             ((M.OP == OP_SH) && M.valA[0]);
`ifdef MEM_UNALIGNED_EN
    ri     = 1'b0;
`else
    ri     = is_merge_op(M.OP);
`endif
    fault  = ade_l | ade_s | ri;
    issue  = m_valid & is_mem & ~fault & ~flush;
  end

  // FSM next state, bus handshake, stall and write-back bundle
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    res_d      = res_q;
    dreq_valid = 1'b0;
    pcm_stall  = 1'b0;
    w_valid    = 1'b0;

    W_pre.valA     = M.valA;
    W_pre.valB     = M.valB;
    W_pre.regw     = M.regw;
    W_pre.pc       = M.pc;
    W_pre.exp      = M.exp;
    W_pre.exp.ADEL = M.exp.ADEL | ade_l;
    W_pre.exp.ADES = M.exp.ADES | ade_s;
    W_pre.exp.RI   = M.exp.RI | ri;
    W_pre.hi_w     = M.hi_w;
    W_pre.lo_w     = M.lo_w;
    W_pre.t        = M.t;
    W_pre.badvaddr = (ade_l | ade_s) ? M.valA : '0;
    if (fault) begin
      W_pre.regw = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (issue) begin
          dreq_valid = 1'b1;
          pcm_stall  = 1'b1;
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              state_d = DONE;
              res_d   = load_data;
            end else begin
              state_d = WAIT;
            end
          end else begin
            state_d = REQ;
          end
        end else begin
          w_valid = m_valid & ~flush;
        end
      end
      REQ: begin
        // An asserted request is held even across a flush; kill marks it
        dreq_valid = 1'b1;
        pcm_stall  = 1'b1;
        kill_d     = kill_q | flush;
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            state_d = DONE;
            res_d   = load_data;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        pcm_stall = 1'b1;
        kill_d    = kill_q | flush;
        if (dresp_data_ok) begin
          state_d = DONE;
          res_d   = load_data;
        end
      end
      DONE: begin
        W_pre.valA = res_q;
        w_valid    = m_valid & ~(kill_q | flush);
        if (kill_q | flush) begin
          W_pre.regw = 1'b0;
        end
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      dreq_valid = 1'b0;
      pcm_stall  = 1'b0;
      w_valid    = 1'b0;
      W_pre      = '0;
    end
  end

  // State, kill flag and captured load result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected bus requests and write-back
// bundles are queued at stimulus time and checked by independent monitors.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk;
  logic        reset;
  M_type       M;
  logic        m_valid;
  logic        flush;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  W_type       W_pre;
  logic        w_valid;
  logic        pcm_stall;

  memory_access dut (
    .clk           (clk),
    .reset         (reset),
    .M             (M),
    .m_valid       (m_valid),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .W_pre         (W_pre),
    .w_valid       (w_valid),
    .pcm_stall     (pcm_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic        chk_val;
    logic [31:0] valA;
    logic        regw;
    exp_t        ex;
    logic [31:0] bad;
    logic [4:0]  t;
  } wexp_t;

  req_t        req_q[$];
  wexp_t       w_q[$];
  int unsigned checks;
  int unsigned failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic adel, input logic ades, input logic ri);
    exp_t e;
    e      = '0;
    e.ADEL = adel;
    e.ADES = ades;
    e.RI   = ri;
    return e;
  endfunction

  task automatic push_req(input logic [31:0] a, input logic [2:0] s, input logic [3:0] st,
                          input logic [31:0] d);
    req_t r;
    r.addr = a; r.size = s; r.strobe = st; r.data = d;
    req_q.push_back(r);
  endtask

  task automatic push_w(input logic cv, input logic [31:0] v, input logic rw, input exp_t ex,
                        input logic [31:0] bad);
    wexp_t w;
    w.chk_val = cv; w.valA = v; w.regw = rw; w.ex = ex; w.bad = bad; w.t = 5'd9;
    w_q.push_back(w);
  endtask

  task automatic set_m(input op_t op, input logic rm_i, input logic wm_i, input logic regw_i,
                       input logic [31:0] addr, input logic [31:0] rt);
    M      = '0;
    M.OP   = op;
    M.rm   = rm_i;
    M.wm   = wm_i;
    M.regw = regw_i;
    M.valA = addr;
    M.valB = rt;
    M.pc   = 32'hBFC0_0100;
    M.t    = 5'd9;
  endtask

  // Write-back monitor
  always @(negedge clk) begin
    wexp_t e;
    if (!reset && w_valid) begin
      if (w_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w_unexpected: got w_valid=1 valA=%h expected no write-back", W_pre.valA);
      end else begin
        e = w_q.pop_front();
        if (e.chk_val) chk("w_valA", W_pre.valA, e.valA);
        chk("w_regw", 32'(W_pre.regw), 32'(e.regw));
        chk("w_exp", 32'(W_pre.exp), 32'(e.ex));
        chk("w_badvaddr", W_pre.badvaddr, e.bad);
        chk("w_t", 32'(W_pre.t), 32'(e.t));
      end
    end
  end

  // Bus request monitor: every cycle a request is shown it must match
  always @(negedge clk) begin
    req_t r;
    if (!reset && dreq_valid) begin
      if (req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_unexpected: got dreq_valid=1 addr=%h expected no request", dreq_addr);
      end else begin
        r = req_q[0];
        chk("req_addr", dreq_addr, r.addr);
        chk("req_size", 32'(dreq_size), 32'(r.size));
        chk("req_strobe", 32'(dreq_strobe), 32'(r.strobe));
        chk("req_data", dreq_data, r.data);
        if (dresp_addr_ok) void'(req_q.pop_front());
      end
    end
  end

  // Runs one memory op with addr_ok after a_dly cycles and data_ok d_dly after that
  task automatic mem_op(input op_t op, input logic rm_i, input logic wm_i,
                        input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rdata,
                        input int unsigned a_dly, input int unsigned d_dly, input bit flush_wait,
                        input int unsigned exp_stalls, input int unsigned exp_reqcyc,
                        output logic done_wv, output logic done_regw);
    int unsigned c, stalls, reqcyc;
    bit done;
    set_m(op, rm_i, wm_i, rm_i, addr, rt);
    m_valid = 1'b1;
    c = 0; stalls = 0; reqcyc = 0; done = 1'b0;
    done_wv = 1'b0; done_regw = 1'b0;
    while (!done && c < 30) begin
      dresp_addr_ok = (c == a_dly);
      dresp_data_ok = (c == a_dly + d_dly);
      dresp_data    = (c == a_dly + d_dly) ? rdata : 32'hDEAD_BEEF;
      flush         = flush_wait && (c == a_dly + 1);
      @(negedge clk);
      if (dreq_valid) reqcyc++;
      if (pcm_stall) stalls++;
      else begin
        done      = 1'b1;
        done_wv   = w_valid;
        done_regw = W_pre.regw;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL mem_timeout: got stall still high after %0d cycles expected completion", c);
    end
    chk("stall_cycles", stalls, exp_stalls);
    chk("req_cycles", reqcyc, exp_reqcyc);
    m_valid = 1'b0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
  endtask

  // Single-cycle op that must neither stall nor touch the bus
  task automatic single(input op_t op, input logic rm_i, input logic wm_i, input logic regw_i,
                        input logic [31:0] addr, input logic [31:0] rt);
    set_m(op, rm_i, wm_i, regw_i, addr, rt);
    m_valid = 1'b1;
    @(negedge clk);
    chk("single_stall", 32'(pcm_stall), 32'd0);
    chk("single_dreq", 32'(dreq_valid), 32'd0);
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wv, rw;
    checks = 0; failures = 0;
    flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    reset = 1'b1;
    // Live load presented during reset: outputs must still read as reset values
    set_m(OP_LW, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h0);
    m_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rst_pcm_stall", 32'(pcm_stall), 32'd0);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    checks++;
    if (W_pre !== '0) begin
      failures++;
      $display("FAIL rst_W_pre: got valA=%h regw=%b expected all zero", W_pre.valA, W_pre.regw);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_valid = 1'b0; M = '0;

    // Non-memory pass-through
    push_w(1'b1, 32'h1234_5678, 1'b1, mk_exp(0, 0, 0), 32'h0);
    single(OP_NOP, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h5555_AAAA);

    // Loads
    push_req(32'h1003, 3'd0, 4'b0000, 32'h0);
    push_w(1'b1, 32'hFFFF_FF80, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LB, 1'b1, 1'b0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0, 1, 1, wv, rw);

    push_req(32'h1003, 3'd0, 4'b0000, 32'h0);
    push_w(1'b1, 32'h0000_0080, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LBU, 1'b1, 1'b0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0, 1, 1, wv, rw);

    push_req(32'h1002, 3'd1, 4'b0000, 32'h0);
    push_w(1'b1, 32'hFFFF_80FF, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LH, 1'b1, 1'b0, 32'h1002, 32'h0, 32'h80FF_FFFF, 1, 1, 1'b0, 3, 2, wv, rw);

    push_req(32'h1000, 3'd1, 4'b0000, 32'h0);
    push_w(1'b1, 32'h0000_F00D, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LHU, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h1234_F00D, 0, 2, 1'b0, 3, 1, wv, rw);

    push_req(32'h1000, 3'd2, 4'b0000, 32'h0);
    push_w(1'b1, 32'h0102_0304, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LW, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0102_0304, 0, 0, 1'b0, 1, 1, wv, rw);

    // Stores
    push_req(32'h2002, 3'd1, 4'b1100, 32'hABCD_ABCD);
    push_w(1'b0, 32'h0, 1'b0, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_SH, 1'b0, 1'b1, 32'h2002, 32'h1234_ABCD, 32'h0, 2, 0, 1'b0, 3, 3, wv, rw);

    push_req(32'h3001, 3'd0, 4'b0010, 32'hA5A5_A5A5);
    push_w(1'b0, 32'h0, 1'b0, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_SB, 1'b0, 1'b1, 32'h3001, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 1, 1, wv, rw);

    push_req(32'h3000, 3'd2, 4'b1111, 32'hCAFE_F00D);
    push_w(1'b0, 32'h0, 1'b0, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_SW, 1'b0, 1'b1, 32'h3000, 32'hCAFE_F00D, 32'h0, 1, 2, 1'b0, 4, 2, wv, rw);

    // Alignment faults
    push_w(1'b1, 32'h1001, 1'b0, mk_exp(1, 0, 0), 32'h1001);
    single(OP_LW, 1'b1, 1'b0, 1'b1, 32'h1001, 32'h0);
    push_w(1'b1, 32'h1003, 1'b0, mk_exp(1, 0, 0), 32'h1003);
    single(OP_LH, 1'b1, 1'b0, 1'b1, 32'h1003, 32'h0);
    push_w(1'b1, 32'h1001, 1'b0, mk_exp(1, 0, 0), 32'h1001);
    single(OP_LHU, 1'b1, 1'b0, 1'b1, 32'h1001, 32'h0);
    push_w(1'b1, 32'h3002, 1'b0, mk_exp(0, 1, 0), 32'h3002);
    single(OP_SW, 1'b0, 1'b1, 1'b0, 32'h3002, 32'h1111_2222);
    push_w(1'b1, 32'h3003, 1'b0, mk_exp(0, 1, 0), 32'h3003);
    single(OP_SH, 1'b0, 1'b1, 1'b0, 32'h3003, 32'h1111_2222);

    // Partial-word merges
`ifdef MEM_UNALIGNED_EN
    push_req(32'h1000, 3'd2, 4'b0000, 32'h0);
    push_w(1'b1, 32'h3344_CCDD, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LWL, 1'b1, 1'b0, 32'h1001, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 1'b0, 1, 1, wv, rw);
    push_req(32'h1000, 3'd2, 4'b0000, 32'h0);
    push_w(1'b1, 32'hAABB_1122, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LWR, 1'b1, 1'b0, 32'h1002, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 1'b0, 1, 1, wv, rw);
    push_req(32'h1000, 3'd2, 4'b0011, 32'h0000_1122);
    push_w(1'b0, 32'h0, 1'b0, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_SWL, 1'b0, 1'b1, 32'h1001, 32'h1122_3344, 32'h0, 0, 0, 1'b0, 1, 1, wv, rw);
    push_req(32'h1000, 3'd2, 4'b1100, 32'h3344_0000);
    push_w(1'b0, 32'h0, 1'b0, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_SWR, 1'b0, 1'b1, 32'h1002, 32'h1122_3344, 32'h0, 0, 0, 1'b0, 1, 1, wv, rw);
`else
    push_w(1'b1, 32'h1001, 1'b0, mk_exp(0, 0, 1), 32'h0);
    single(OP_LWL, 1'b1, 1'b0, 1'b1, 32'h1001, 32'hAABB_CCDD);
    push_w(1'b1, 32'h1002, 1'b0, mk_exp(0, 0, 1), 32'h0);
    single(OP_LWR, 1'b1, 1'b0, 1'b1, 32'h1002, 32'hAABB_CCDD);
    push_w(1'b1, 32'h1001, 1'b0, mk_exp(0, 0, 1), 32'h0);
    single(OP_SWL, 1'b0, 1'b1, 1'b0, 32'h1001, 32'h1122_3344);
    push_w(1'b1, 32'h1002, 1'b0, mk_exp(0, 0, 1), 32'h0);
    single(OP_SWR, 1'b0, 1'b1, 1'b0, 32'h1002, 32'h1122_3344);
`endif

    // Flush pulse while waiting for data: transaction completes, result killed
    push_req(32'h1000, 3'd2, 4'b0000, 32'h0);
    mem_op(OP_LW, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h7777_7777, 0, 4, 1'b1, 5, 1, wv, rw);
    chk("kill_w_valid", 32'(wv), 32'd0);
    chk("kill_regw", 32'(rw), 32'd0);

    // Flush in IDLE suppresses the request entirely
    set_m(OP_LW, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h0);
    m_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_dreq", 32'(dreq_valid), 32'd0);
    chk("idle_flush_stall", 32'(pcm_stall), 32'd0);
    chk("idle_flush_wvalid", 32'(w_valid), 32'd0);
    @(posedge clk); #1;
    m_valid = 1'b0; flush = 1'b0;

    // Reset while in WAIT
    set_m(OP_LW, 1'b1, 1'b0, 1'b1, 32'h5000, 32'h0);
    m_valid = 1'b1; dresp_addr_ok = 1'b1;
    push_req(32'h5000, 3'd2, 4'b0000, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("wait_stall", 32'(pcm_stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rstw_pcm_stall", 32'(pcm_stall), 32'd0);
    chk("rstw_w_valid", 32'(w_valid), 32'd0);
    checks++;
    if (W_pre !== '0) begin
      failures++;
      $display("FAIL rstw_W_pre: got valA=%h regw=%b expected all zero", W_pre.valA, W_pre.regw);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_valid = 1'b0; M = '0;
    @(negedge clk);
    chk("post_rst_stall", 32'(pcm_stall), 32'd0);
    chk("post_rst_dreq", 32'(dreq_valid), 32'd0);
    @(posedge clk); #1;

    // Fresh load after reset
    push_req(32'h4000, 3'd2, 4'b0000, 32'h0);
    push_w(1'b1, 32'h0A0B_0C0D, 1'b1, mk_exp(0, 0, 0), 32'h0);
    mem_op(OP_LW, 1'b1, 1'b0, 32'h4000, 32'h0, 32'h0A0B_0C0D, 1, 0, 1'b0, 2, 2, wv, rw);

    repeat (3) @(posedge clk);
    chk("w_queue_drained", w_q.size(), 32'd0);
    chk("req_queue_drained", req_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
